hilo_mul_unit: RTL
==================

# hilo_mul_unit

Multi-cycle multiply/divide-style execute unit that consumes the 6-bit ALUControl code produced by the ALU controller for the HI/LO and multiply class of instructions: MULT, MULTU, MUL, MADD, MSUB, MFHI, MFLO, MTHI and MTLO. It sits in the execute stage beside the combinational ALU. It owns the architectural HI and LO registers, runs an iterative multiplier, and raises Busy to stall the pipeline while a multiply is in flight.

## Interface
- BITS_PER_CYCLE, default 2: multiplier bits retired per iteration; legal values are 1, 2 and 4. N = 32/BITS_PER_CYCLE.

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset, synchronous and active-high. One clock; reset is synchronous and active-high.
- Start  in  1  issue strobe for the current ALUControl; sampled only while Busy=0.
- ALUControl  in  6  operation code from the ALU controller.
- A  in  32  rs operand.
- B  in  32  rt operand.
- Result  out  32  registered GPR writeback value for MUL, MFHI and MFLO.
- ResultValid  out  1  one-cycle pulse when Result is new.
- Busy  out  1  stall request; registered.
- Hi  out  32  architectural HI register.
- Lo  out  32  architectural LO register.

## Operation
- Accepted codes:
  - MULT 0x03, MULTU 0x04, MUL 0x13, MADD 0x14, MSUB 0x15
  - MFHI 0x17, MFLO 0x18, MTHI 0x19, MTLO 0x1A
  - Any other code with Start is ignored: no state change, no pulse.
- States: IDLE, MUL, FINISH.
- IDLE, on accepted Start:
  - MTHI: Hi<=A. MTLO: Lo<=A. No ResultValid pulse; Busy stays 0.
  - MFHI/MFLO: Result<=Hi/Lo; ResultValid high for the next cycle.
  - Multiply class: latch operands and code; go to MUL; Busy<=1.
- Signed ops (MULT, MUL, MADD, MSUB):
  - Operate on operand magnitudes.
  - Negate the 64-bit product when the operand signs differ.
  - MULTU is fully unsigned.
- MUL: iterate N cycles, shifting BITS_PER_CYCLE multiplier bits per cycle into a 64-bit accumulator; then go to FINISH.
- FINISH, one cycle, then back to IDLE:
  - MULT/MULTU: {Hi,Lo}<=P.
  - MADD: {Hi,Lo}<={Hi,Lo}+P, 64-bit wrap.
  - MSUB: {Hi,Lo}<={Hi,Lo}-P, 64-bit wrap.
  - MUL: Result<=P[31:0], ResultValid pulse; Hi/Lo unchanged.
- Start while Busy=1 is ignored. The pipeline holds the instruction and reissues it.
- Reset values: Hi=Lo=Result=0, ResultValid=0, Busy=0, state IDLE.
- Rst mid-operation aborts the multiply; all registers return to reset values on the same edge.

## Timing
- Start sampled at edge E0:
  - MTHI/MTLO: Hi/Lo updated at E0.
  - MFHI/MFLO: Result and ResultValid visible in the cycle after E0.
- Multiply class:
  - Busy=1 from E0 through edge E(N+1), i.e. N+1 cycles (17 at the default).
  - Hi/Lo/Result update at E(N+1).
  - ResultValid (MUL only) is high, and Busy is 0, in the cycle after E(N+1).
  - A new Start may be accepted at E(N+2).
- ResultValid is never high for more than one cycle per operation.
- MFHI issued at E(N+2) returns the updated Hi.

## Configuration
- MADD_MSUB_EN defined: MADD and MSUB are supported as above.
- MADD_MSUB_EN undefined:
  - 0x14 and 0x15 are treated as unknown codes and ignored.
  - The 64-bit accumulate adder/subtractor is not built.

## Structure
- Shared package alu_ctrl_pkg holds:
  - All 6-bit ALUControl code constants (0x00–0x21), also used by the ALU controller and the ALU.
  - The state enum for this block.
- One sub-module, mul_iter_core:
  - Unsigned 32x32 iterative multiplier with start/done and the BITS_PER_CYCLE parameter.
  - Sign handling, HI/LO, accumulate and the FSM stay in hilo_mul_unit.

## Test plan
- Reset, then MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> Busy high 17 cycles; Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT A=0xFFFFFFFD B=7, then MFLO -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Result=0xFFFFFFEB with a single ResultValid pulse.
- MTHI 0, MTLO 10, MADD A=2 B=3 -> Lo=16. Then MSUB A=4 B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFC.
- MTHI 0x55, MTLO 0xAA, then MUL A=0x00010001 B=0x00010000 -> Result=0x00010000 with one pulse; Hi=0x55 and Lo=0xAA unchanged.
- MFHI Start during Busy -> ignored, no pulse. Rst asserted at iteration 5 -> next cycle Busy=0, Hi=Lo=0, ResultValid=0.
- Build without MADD_MSUB_EN, MADD A=2 B=3 -> Busy stays 0; Hi/Lo unchanged.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// ALUControl code space shared by the ALU controller, the ALU and the HI/LO unit.
// Also holds the HI/LO multiply unit state encoding.
package alu_ctrl_pkg;

  localparam logic [5:0] alu_and   = 6'h00;
  localparam logic [5:0] alu_or    = 6'h01;
  localparam logic [5:0] alu_add   = 6'h02;
  localparam logic [5:0] alu_mult  = 6'h03;
  localparam logic [5:0] alu_multu = 6'h04;
  localparam logic [5:0] alu_sub   = 6'h05;
  localparam logic [5:0] alu_slt   = 6'h06;
  localparam logic [5:0] alu_sltu  = 6'h07;
  localparam logic [5:0] alu_xor   = 6'h08;
  localparam logic [5:0] alu_nor   = 6'h09;
  localparam logic [5:0] alu_sll   = 6'h0a;
  localparam logic [5:0] alu_srl   = 6'h0b;
  localparam logic [5:0] alu_sra   = 6'h0c;
  localparam logic [5:0] alu_sllv  = 6'h0d;
  localparam logic [5:0] alu_srlv  = 6'h0e;
  localparam logic [5:0] alu_srav  = 6'h0f;
  localparam logic [5:0] alu_lui   = 6'h10;
  localparam logic [5:0] alu_div   = 6'h11;
  localparam logic [5:0] alu_divu  = 6'h12;
  localparam logic [5:0] alu_mul   = 6'h13;
  localparam logic [5:0] alu_madd  = 6'h14;
  localparam logic [5:0] alu_msub  = 6'h15;
  localparam logic [5:0] alu_maddu = 6'h16;
  localparam logic [5:0] alu_mfhi  = 6'h17;
  localparam logic [5:0] alu_mflo  = 6'h18;
  localparam logic [5:0] alu_mthi  = 6'h19;
  localparam logic [5:0] alu_mtlo  = 6'h1a;
  localparam logic [5:0] alu_msubu = 6'h1b;
  localparam logic [5:0] alu_clz   = 6'h1c;
  localparam logic [5:0] alu_clo   = 6'h1d;
  localparam logic [5:0] alu_movn  = 6'h1e;
  localparam logic [5:0] alu_movz  = 6'h1f;
  localparam logic [5:0] alu_rotr  = 6'h20;
  localparam logic [5:0] alu_rotrv = 6'h21;

  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_mul    = 2'd1,
    st_finish = 2'd2
  } hm_state_t;

endpackage

// File: rtl/mul_iter_core.sv
// Unsigned 32x32 iterative multiplier, BITS_PER_CYCLE multiplier bits per cycle.
// done is high during the cycle whose closing edge retires the last digit.
module mul_iter_core
  import alu_ctrl_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [63:0] prod
);

  localparam int K  = BITS_PER_CYCLE;
  localparam int N  = 32 / K;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [31:0]   ma;
  logic [31:0]   mb;
  logic [63:0]   acc;
  logic [63:0]   part;
  logic [CW-1:0] cnt;
  logic          run;

  assign part = {32'b0, ma} * {{(64-K){1'b0}}, mb[31 -: K]};
  assign done = run && (cnt == LAST);
  assign prod = acc;

  // MSB-first shift-and-add over the multiplier digits
  always_ff @(posedge clk) begin
    if (rst) begin
      ma  <= '0;
      mb  <= '0;
      acc <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      ma  <= a;
      mb  <= b;
      acc <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      acc <= {acc[63-K:0], {K{1'b0}}} + part;
      mb  <= mb << K;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_mul_unit.sv
// HI/LO owner and multi-cycle multiply unit beside the execute-stage ALU.
// Optional MADD_MSUB_EN builds the 64-bit HI/LO accumulate path.
module hilo_mul_unit
  import alu_ctrl_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [5:0]  ALUControl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  output logic        ResultValid,
  output logic        Busy,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  hm_state_t   state, state_n;
  logic [5:0]  op, op_n;
  logic        neg, neg_n;
  logic [31:0] hi_n, lo_n, result_n;
  logic        rv_n, busy_n;
  logic        core_start, core_done;
  logic [63:0] core_prod;
  logic [63:0] p;
  logic [31:0] ma, mb;

  logic is_mthi, is_mtlo, is_mfhi, is_mflo;
  logic is_madd, is_msub, is_signed, is_mulop;

  assign is_mthi = (ALUControl == alu_mthi);
  assign is_mtlo = (ALUControl == alu_mtlo);
  assign is_mfhi = (ALUControl == alu_mfhi);
  assign is_mflo = (ALUControl == alu_mflo);
`ifdef MADD_MSUB_EN
  assign is_madd = (ALUControl == alu_madd);
  assign is_msub = (ALUControl == alu_msub);
`else
  assign is_madd = 1'b0;
  assign is_msub = 1'b0;
`endif
  assign is_signed = (ALUControl == alu_mult)
                   | (ALUControl == alu_mul)
                   | is_madd | is_msub;
  assign is_mulop  = is_signed | (ALUControl == alu_multu);

  assign ma = (is_signed && A[31]) ? 32'd0 - A : A;
  assign mb = (is_signed && B[31]) ? 32'd0 - B : B;
  assign p  = neg ? 64'd0 - core_prod : core_prod;

`ifdef MADD_MSUB_EN
  logic [63:0] acc_sum;
  assign acc_sum = (op == alu_msub) ? {Hi, Lo} - p
                                    : {Hi, Lo} + p;
`endif

  mul_iter_core #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_core (
    .clk  (Clk),
    .rst  (Rst),
    .start(core_start),
    .a    (ma),
    .b    (mb),
    .done (core_done),
    .prod (core_prod)
  );

  // Next-state, HI/LO and writeback decisions
  always_comb begin
    state_n    = state;
    op_n       = op;
    neg_n      = neg;
    hi_n       = Hi;
    lo_n       = Lo;
    result_n   = Result;
    rv_n       = 1'b0;
    busy_n     = Busy;
    core_start = 1'b0;
    unique case (state)
      st_idle: begin
        if (Start) begin
          unique case (1'b1)
            is_mthi: hi_n = A;
            is_mtlo: lo_n = A;
            is_mfhi: begin
              result_n = Hi;
              rv_n     = 1'b1;
            end
            is_mflo: begin
              result_n = Lo;
              rv_n     = 1'b1;
            end
            is_mulop: begin
              state_n    = st_mul;
              busy_n     = 1'b1;
              op_n       = ALUControl;
              neg_n      = is_signed & (A[31] ^ B[31]);
              core_start = 1'b1;
            end
            default: ;
          endcase
        end
      end
      st_mul: begin
        if (core_done) state_n = st_finish;
      end
      st_finish: begin
        state_n = st_idle;
        busy_n  = 1'b0;
        unique case (1'b1)
          (op == alu_mul): begin
            result_n = p[31:0];
            rv_n     = 1'b1;
          end
`ifdef MADD_MSUB_EN
          (op == alu_madd) || (op == alu_msub):
            {hi_n, lo_n} = acc_sum;
`endif
          default: {hi_n, lo_n} = p;
        endcase
      end
      default: state_n = st_idle;
    endcase
  end

  // Architectural and control registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= st_idle;
      op          <= '0;
      neg         <= 1'b0;
      Hi          <= '0;
      Lo          <= '0;
      Result      <= '0;
      ResultValid <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      state       <= state_n;
      op          <= op_n;
      neg         <= neg_n;
      Hi          <= hi_n;
      Lo          <= lo_n;
      Result      <= result_n;
      ResultValid <= rv_n;
      Busy        <= busy_n;
    end
  end

endmodule
